// File: rtl/l2_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// Bus interfaces for l2_mem_arbiter.
//
// l2_req_if : requester side, NUM_REQ L2 caches packed side by side.
//   master  - the L2 caches (drive level-held requests, receive ready pulses)
//   slave   - the arbiter
//   req_read/req_write         per-requester level-held requests
//   req_address/req_write_data packed, requester i at [i*W +: W]
//   req_read_data              read data, valid with the req_read_ready pulse
//   req_read_ready/_write_ready one-hot, one-cycle completion pulses
//
// l2_mem_if : shared downstream L3/memory port.
//   master  - the arbiter (holds a request until the matching ready)
//   slave   - the L3/memory model
//   mem_read_req/mem_write_req, mem_address, mem_write_data
//   mem_read_data (valid with mem_read_ready), mem_read_ready, mem_write_ready
// ---------------------------------------------------------------------------
interface l2_req_if #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [NUM_REQ-1:0]            req_read;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_address;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_write_data;
  logic [DATA_WIDTH-1:0]         req_read_data;
  logic [NUM_REQ-1:0]            req_read_ready;
  logic [NUM_REQ-1:0]            req_write_ready;

  modport master (
    output req_read, req_write, req_address, req_write_data,
    input  req_read_data, req_read_ready, req_write_ready
  );

  modport slave (
    input  req_read, req_write, req_address, req_write_data,
    output req_read_data, req_read_ready, req_write_ready
  );
endinterface

interface l2_mem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  mem_read_req;
  logic                  mem_write_req;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_write_data;
  logic [DATA_WIDTH-1:0] mem_read_data;
  logic                  mem_read_ready;
  logic                  mem_write_ready;

  modport master (
    output mem_read_req, mem_write_req, mem_address, mem_write_data,
    input  mem_read_data, mem_read_ready, mem_write_ready
  );

  modport slave (
    input  mem_read_req, mem_write_req, mem_address, mem_write_data,
    output mem_read_data, mem_read_ready, mem_write_ready
  );
endinterface

// File: rtl/l2_mem_arbiter.sv
// ---------------------------------------------------------------------------
// l2_mem_arbiter
// Shares one L3/main-memory port among NUM_REQ private L2 caches. Requests
// are level-held; the arbiter grants round-robin, replays the winning request
// downstream and returns a one-cycle ready pulse (plus read data) to the
// winner.
//
// Ports:
//   clk         clock, all logic on the rising edge
//   reset       synchronous, active-low reset
//   req_bus     l2_req_if.slave  - requester side
//   mem_bus     l2_mem_if.master - downstream memory side
//   grant_id    index of the current/last winner
//   busy        high whenever the FSM is outside IDLE
//   timeout_err one-cycle watchdog pulse (only with L2_ARB_TIMEOUT_EN)
//
// Optional feature: define L2_ARB_TIMEOUT_EN to add the BUSY watchdog
// (TIMEOUT_CYCLES) and the timeout_err port. Without it BUSY waits forever.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | no transaction; grant the next pending requester round-robin
// BUSY  | downstream request held until its matching ready (or watchdog)
// DONE  | one turnaround cycle so the winner can drop its request
// ---------------------------------------------------------------------------
module l2_mem_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256,
  localparam int GRANT_W       = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  l2_req_if.slave            req_bus,
  l2_mem_if.master           mem_bus,
  output logic [GRANT_W-1:0] grant_id,
  output logic               busy
`ifdef L2_ARB_TIMEOUT_EN
  ,
  output logic               timeout_err
`endif
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("l2_mem_arbiter: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [GRANT_W-1:0]      last_grant_q, last_grant_d;
  logic [GRANT_W-1:0]      grant_id_q, grant_id_d;
  logic                    mem_rd_q, mem_rd_d;
  logic                    mem_wr_q, mem_wr_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [NUM_REQ-1:0]      rd_rdy_q, rd_rdy_d;
  logic [NUM_REQ-1:0]      wr_rdy_q, wr_rdy_d;

`ifdef L2_ARB_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  // Down-counter loaded on entry to BUSY; terminal count 0 means the
  // TIMEOUT_CYCLES-th BUSY edge has arrived without a matching ready.
  logic [TMR_W-1:0]        tmr_q, tmr_d;
  logic                    timeout_q, timeout_d;
`endif

  logic [NUM_REQ-1:0]      pending;
  logic                    any_pending;
  logic [GRANT_W-1:0]      winner;

  assign pending = req_bus.req_read | req_bus.req_write;

  // Round-robin pick: first pending index at or after last_grant+1, with the
  // wrap done modulo NUM_REQ so non-power-of-2 counts never alias. Scanning
  // offsets from far to near lets the nearest pending index win.
  always_comb begin
    int idx;
    logic [GRANT_W-1:0] idx_w;
    idx         = 0;
    idx_w       = '0;
    winner      = '0;
    any_pending = 1'b0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx   = (int'(last_grant_q) + k) % NUM_REQ;
      idx_w = idx[GRANT_W-1:0];
      if (pending[idx_w]) begin
        winner      = idx_w;
        any_pending = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    mem_rd_d     = mem_rd_q;
    mem_wr_d     = mem_wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    rd_rdy_d     = '0;
    wr_rdy_d     = '0;
`ifdef L2_ARB_TIMEOUT_EN
    tmr_d        = tmr_q;
    timeout_d    = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (any_pending) begin
          grant_id_d = winner;
          addr_d     = req_bus.req_address[int'(winner)*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d    = req_bus.req_write_data[int'(winner)*DATA_WIDTH +: DATA_WIDTH];
          // Write wins over read so a dirty write-back precedes the fill.
          mem_wr_d   = req_bus.req_write[winner];
          mem_rd_d   = ~req_bus.req_write[winner];
          state_d    = ST_BUSY;
`ifdef L2_ARB_TIMEOUT_EN
          tmr_d      = TMR_W'(TIMEOUT_CYCLES - 1);
`endif
        end
      end

      ST_BUSY: begin
        // Only the ready matching the issued op counts.
        if (mem_wr_q && mem_bus.mem_write_ready) begin
          mem_wr_d             = 1'b0;
          wr_rdy_d[grant_id_q] = 1'b1;
          last_grant_d         = grant_id_q;
          state_d              = ST_DONE;
        end else if (mem_rd_q && mem_bus.mem_read_ready) begin
          mem_rd_d             = 1'b0;
          rd_rdy_d[grant_id_q] = 1'b1;
          rdata_d              = mem_bus.mem_read_data;
          last_grant_d         = grant_id_q;
          state_d              = ST_DONE;
        end
`ifdef L2_ARB_TIMEOUT_EN
        else if (tmr_q == '0) begin
          mem_rd_d  = 1'b0;
          mem_wr_d  = 1'b0;
          if (mem_wr_q) begin
            wr_rdy_d[grant_id_q] = 1'b1;
          end else begin
            rd_rdy_d[grant_id_q] = 1'b1;
            rdata_d              = '0;
          end
          timeout_d    = 1'b1;
          last_grant_d = grant_id_q;
          state_d      = ST_DONE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
`endif
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      // Pointer parked on the last index so requester 0 is favoured first.
      last_grant_q <= GRANT_W'(NUM_REQ - 1);
      grant_id_q   <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      rd_rdy_q     <= '0;
      wr_rdy_q     <= '0;
`ifdef L2_ARB_TIMEOUT_EN
      tmr_q        <= '0;
      timeout_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      rd_rdy_q     <= rd_rdy_d;
      wr_rdy_q     <= wr_rdy_d;
`ifdef L2_ARB_TIMEOUT_EN
      tmr_q        <= tmr_d;
      timeout_q    <= timeout_d;
`endif
    end
  end

  assign mem_bus.mem_read_req    = mem_rd_q;
  assign mem_bus.mem_write_req   = mem_wr_q;
  assign mem_bus.mem_address     = addr_q;
  assign mem_bus.mem_write_data  = wdata_q;
  assign req_bus.req_read_data   = rdata_q;
  assign req_bus.req_read_ready  = rd_rdy_q;
  assign req_bus.req_write_ready = wr_rdy_q;
  assign grant_id                = grant_id_q;
  assign busy                    = (state_q != ST_IDLE);
`ifdef L2_ARB_TIMEOUT_EN
  assign timeout_err             = timeout_q;
`endif

endmodule

// File: tb/tb_l2_mem_arbiter.sv
`timescale 1ns/1ps
// Self-checking bench for l2_mem_arbiter: directed scenarios followed by a
// randomized run, all checked against a transaction-level reference model.
module tb_l2_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int GW = $clog2(N);
  localparam int TO = 8;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic [GW-1:0] grant_id;
  logic          busy;
`ifdef L2_ARB_TIMEOUT_EN
  logic          timeout_err;
`endif

  l2_req_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) rq();
  l2_mem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) mm();

  l2_mem_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_bus(rq),
    .mem_bus(mm),
    .grant_id(grant_id),
    .busy(busy)
`ifdef L2_ARB_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  // Stimulus state
  logic [N-1:0]  rd_v, wr_v;
  logic [AW-1:0] addr_v [N];
  logic [DW-1:0] wd_v   [N];
  logic          mrd_rdy, mwr_rdy;
  logic [DW-1:0] mrd_data;

  assign rq.req_read        = rd_v;
  assign rq.req_write       = wr_v;
  assign mm.mem_read_ready  = mrd_rdy;
  assign mm.mem_write_ready = mwr_rdy;
  assign mm.mem_read_data   = mrd_data;

  always_comb begin
    rq.req_address    = '0;
    rq.req_write_data = '0;
    for (int i = 0; i < N; i++) begin
      rq.req_address[i*AW +: AW]    = addr_v[i];
      rq.req_write_data[i*DW +: DW] = wd_v[i];
    end
  end

  // Memory / requester behaviour controls
  int mem_mode;   // 0 silent, 1 random latency + noise, 2 one-cycle response
  bit hold_mode;  // requesters keep requesting after completion
  bit gen_en;     // random new requests
  bit mseen;
  int mwait;
  bit prev_dreq;
  int g_id_q[$];
  int g_cyc_q[$];

  // Reference model state (transaction level)
  int            cyc;
  int            free_cyc;
  bit            ov;
  int            ow;
  bit            ow_wr;
  logic [AW-1:0] oa;
  logic [DW-1:0] od;
  int            last;
  int            gid;
  logic [DW-1:0] rdata_exp;
  int            bcnt;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int rr_pick(input logic [N-1:0] p, input int l);
    for (int k = 1; k <= N; k++) begin
      if (p[(l + k) % N]) return (l + k) % N;
    end
    return 0;
  endfunction

  // One clock: model the edge, check outputs, then update stimulus.
  task automatic cycle();
    logic [N-1:0] pend, exp_rr, exp_wr;
    bit done_now, exp_to, dreq;
    int op;
    @(posedge clk);
    #1;
    cyc++;
    pend     = rd_v | wr_v;
    exp_rr   = '0;
    exp_wr   = '0;
    done_now = 1'b0;
    exp_to   = 1'b0;

    if (!reset) begin
      ov        = 1'b0;
      last      = N - 1;
      gid       = 0;
      rdata_exp = '0;
      free_cyc  = cyc + 1;
    end else if (ov) begin
      if (ow_wr ? mwr_rdy : mrd_rdy) begin
        done_now = 1'b1;
        if (ow_wr) exp_wr[ow] = 1'b1;
        else begin
          exp_rr[ow] = 1'b1;
          rdata_exp  = mrd_data;
        end
      end
`ifdef L2_ARB_TIMEOUT_EN
      else begin
        bcnt++;
        if (bcnt >= TO) begin
          done_now = 1'b1;
          exp_to   = 1'b1;
          if (ow_wr) exp_wr[ow] = 1'b1;
          else begin
            exp_rr[ow] = 1'b1;
            rdata_exp  = '0;
          end
        end
      end
`endif
      if (done_now) begin
        ov       = 1'b0;
        last     = ow;
        free_cyc = cyc + 2;
      end
    end else if (cyc >= free_cyc && pend != '0) begin
      ow    = rr_pick(pend, last);
      ov    = 1'b1;
      ow_wr = wr_v[ow];
      oa    = addr_v[ow];
      od    = wd_v[ow];
      gid   = ow;
      bcnt  = 0;
    end

    chk("mem_read_req",    mm.mem_read_req,    ov && !ow_wr);
    chk("mem_write_req",   mm.mem_write_req,   ov && ow_wr);
    chk("req_read_ready",  rq.req_read_ready,  exp_rr);
    chk("req_write_ready", rq.req_write_ready, exp_wr);
    chk("req_read_data",   rq.req_read_data,   rdata_exp);
    chk("grant_id",        grant_id,           gid);
    chk("busy",            busy,               ov || done_now);
`ifdef L2_ARB_TIMEOUT_EN
    chk("timeout_err",     timeout_err,        exp_to);
`endif
    if (ov) begin
      chk("mem_address",    mm.mem_address,    oa);
      chk("mem_write_data", mm.mem_write_data, od);
    end
    if (!reset) begin
      chk("rst_mem_address",    mm.mem_address,    '0);
      chk("rst_mem_write_data", mm.mem_write_data, '0);
    end

    dreq = mm.mem_read_req | mm.mem_write_req;
    if (dreq && !prev_dreq) begin
      g_id_q.push_back(int'(grant_id));
      g_cyc_q.push_back(cyc);
    end
    prev_dreq = dreq;

    // L2 requesters
    if (!hold_mode) begin
      for (int i = 0; i < N; i++) begin
        if (rq.req_read_ready[i])  rd_v[i] = 1'b0;
        if (rq.req_write_ready[i]) wr_v[i] = 1'b0;
      end
    end
    if (gen_en) begin
      for (int i = 0; i < N; i++) begin
        if (!rd_v[i] && !wr_v[i]) begin
          if ($urandom_range(0, 3) == 0) begin
            op        = int'($urandom_range(0, 3));
            rd_v[i]   = (op != 2);
            wr_v[i]   = (op >= 2);
            addr_v[i] = $urandom;
            wd_v[i]   = $urandom;
          end
        end else if ($urandom_range(0, 63) == 0) begin
          rd_v[i] = 1'b0;
          wr_v[i] = 1'b0;
        end
      end
    end

    // Memory model
    mrd_rdy  = 1'b0;
    mwr_rdy  = 1'b0;
    mrd_data = $urandom;
    if (mem_mode != 0) begin
      if (!dreq) begin
        mseen = 1'b0;
        if (mem_mode == 1 && $urandom_range(0, 7) == 0) begin
          if ($urandom_range(0, 1) == 1) mrd_rdy = 1'b1;
          else                           mwr_rdy = 1'b1;
        end
      end else begin
        if (!mseen) begin
          mseen = 1'b1;
          mwait = (mem_mode == 1) ? int'($urandom_range(0, 3)) : 0;
        end
        if (mwait == 0) begin
          if (mm.mem_write_req) mwr_rdy = 1'b1;
          else                  mrd_rdy = 1'b1;
        end else begin
          mwait--;
          if (mem_mode == 1 && $urandom_range(0, 3) == 0) begin
            if (mm.mem_write_req) mrd_rdy = 1'b1;
            else                  mwr_rdy = 1'b1;
          end
        end
      end
    end
  endtask

  task automatic do_reset();
    rd_v  = '0;
    wr_v  = '0;
    reset = 1'b0;
    cycle();
    cycle();
    reset = 1'b1;
  endtask

  initial begin
    bit seen;
    int n;
    rd_v      = '0;
    wr_v      = '0;
    mrd_rdy   = 1'b0;
    mwr_rdy   = 1'b0;
    mrd_data  = '0;
    for (int i = 0; i < N; i++) begin
      addr_v[i] = '0;
      wd_v[i]   = '0;
    end
    mem_mode  = 0;
    hold_mode = 1'b0;
    gen_en    = 1'b0;
    mseen     = 1'b0;
    mwait     = 0;
    prev_dreq = 1'b0;
    cyc       = 0;
    free_cyc  = 0;
    ov        = 1'b0;
    ow        = 0;
    ow_wr     = 1'b0;
    oa        = '0;
    od        = '0;
    last      = N - 1;
    gid       = 0;
    rdata_exp = '0;
    bcnt      = 0;

    // Single read from requester 2
    do_reset();
    addr_v[2] = 32'h0000_1040;
    rd_v      = 4'b0100;
    cycle();
    chk("sr_mem_read_req", mm.mem_read_req, 1'b1);
    chk("sr_mem_address",  mm.mem_address,  32'h0000_1040);
    mrd_rdy  = 1'b1;
    mrd_data = 32'hDEAD_BEEF;
    cycle();
    chk("sr_read_ready", rq.req_read_ready, 4'b0100);
    chk("sr_read_data",  rq.req_read_data,  32'hDEAD_BEEF);
    chk("sr_grant_id",   grant_id,          2);
    repeat (3) cycle();

    // Round robin with all requesters holding reads, 1-cycle memory
    do_reset();
    mem_mode  = 2;
    hold_mode = 1'b1;
    for (int i = 0; i < N; i++) addr_v[i] = 32'h100 * (i + 1);
    rd_v = '1;
    g_id_q.delete();
    g_cyc_q.delete();
    repeat (16) cycle();
    chk("rr_grant_count", g_id_q.size() >= 5, 1'b1);
    for (int k = 0; k < 5 && k < g_id_q.size(); k++) begin
      chk("rr_grant_seq", g_id_q[k], k % N);
      if (k > 0) chk("rr_spacing", g_cyc_q[k] - g_cyc_q[k-1], 3);
    end
    hold_mode = 1'b0;
    rd_v      = '0;
    repeat (4) cycle();

    // Write priority: requester 1 asks read and write together
    do_reset();
    mem_mode  = 2;
    addr_v[1] = 32'h20;
    wd_v[1]   = 32'h55AA_55AA;
    rd_v      = 4'b0010;
    wr_v      = 4'b0010;
    cycle();
    chk("wp_write_req",  mm.mem_write_req,  1'b1);
    chk("wp_read_req",   mm.mem_read_req,   1'b0);
    chk("wp_write_data", mm.mem_write_data, 32'h55AA_55AA);
    cycle();
    chk("wp_write_ready", rq.req_write_ready, 4'b0010);
    chk("wp_read_req2",   mm.mem_read_req,   1'b0);
    repeat (5) cycle();

    // Wrong-type ready is ignored
    do_reset();
    mem_mode  = 0;
    addr_v[3] = 32'h300;
    rd_v      = 4'b1000;
    cycle();
    cycle();
    mwr_rdy = 1'b1;
    cycle();
    chk("wr_busy",     busy,                                   1'b1);
    chk("wr_no_pulse", rq.req_read_ready | rq.req_write_ready, '0);
    chk("wr_rd_req",   mm.mem_read_req,                        1'b1);
    mrd_rdy  = 1'b1;
    mrd_data = 32'h1234_5678;
    cycle();
    chk("wr_read_ready", rq.req_read_ready, 4'b1000);
    chk("wr_read_data",  rq.req_read_data,  32'h1234_5678);
    repeat (3) cycle();

    // Reset in the middle of a read
    do_reset();
    mem_mode  = 0;
    addr_v[1] = 32'h440;
    rd_v      = 4'b0010;
    cycle();
    cycle();
    reset = 1'b0;
    cycle();
    chk("rst_read_req",  mm.mem_read_req,                        1'b0);
    chk("rst_pulses",    rq.req_read_ready | rq.req_write_ready, '0);
    chk("rst_grant_id",  grant_id,                               0);
    rd_v    = '0;
    reset   = 1'b1;
    mrd_rdy = 1'b1;
    cycle();
    chk("rst_stray_ready", rq.req_read_ready, '0);
    repeat (3) cycle();

`ifdef L2_ARB_TIMEOUT_EN
    // Watchdog: a completed read first, then a read the memory never answers
    do_reset();
    mem_mode = 2;
    rd_v     = 4'b0001;
    repeat (4) cycle();
    mem_mode  = 0;
    addr_v[0] = 32'h80;
    rd_v      = 4'b0001;
    cycle();
    seen = 1'b0;
    n    = 0;
    while (!seen && n < 20) begin
      cycle();
      n++;
      if (timeout_err) seen = 1'b1;
    end
    chk("to_seen",       seen,               1'b1);
    chk("to_busy_edges", n,                  TO);
    chk("to_read_ready", rq.req_read_ready,  4'b0001);
    chk("to_read_data",  rq.req_read_data,   '0);
    rd_v = '0;
    repeat (3) cycle();
`else
    seen = 1'b0;
    n    = 0;
`endif

    // Randomized traffic with occasional resets
    do_reset();
    mem_mode = 1;
    gen_en   = 1'b1;
    for (int t = 0; t < 4000; t++) begin
      reset = ($urandom_range(0, 499) != 0);
      cycle();
    end
    reset  = 1'b1;
    gen_en = 1'b0;
    repeat (20) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
